// File: rtl/mux_seq_pkg.sv
// Shared types and sizes for the 8:1 mux select sequencer.
package mux_seq_pkg;
  localparam int NUM_IN = 8;
  localparam int SEL_W  = 3;
  localparam int GAP_W  = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Word-in / bit-out handshake bundle between upstream, the sequencer and the 8:1 mux.
interface mux_sel_sequencer_if;
  import mux_seq_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [NUM_IN-1:0] in_data;
  sel_t              in_nbits;
  logic [NUM_IN-1:0] d_out;
  sel_t              sel;
  logic              bit_valid;
  logic              bit_ready;
  logic              first;
  logic              last;

  modport master (
    input  in_valid, in_data, in_nbits, bit_ready,
    output in_ready, d_out, sel, bit_valid, first, last
  );

  modport slave (
    output in_valid, in_data, in_nbits, bit_ready,
    input  in_ready, d_out, sel, bit_valid, first, last
  );
endinterface

// File: rtl/mux_sel_counter.sv
// Loadable up/down select counter; at_term flags the count sitting on its stored terminal value.
// Load value and terminal are captured together, so the compare never needs the upstream word.
module mux_sel_counter
  import mux_seq_pkg::*;
#(
  parameter bit DOWN = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic en,
  input  sel_t load_val,
  input  sel_t term_val,
  output sel_t q,
  output logic at_term
);
  sel_t term;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= '0;
      term <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q    <= load_val;
      term <= term_val;
    end else if (en) begin
      q <= DOWN ? q - 1'b1 : q + 1'b1;
    end
  end

  assign at_term = (q == term);
endmodule

// File: rtl/mux_sel_sequencer.sv
// Serializes an accepted word through the 8:1 mux select; first bit_valid one cycle after acceptance.
// sel/d_out/first/last hold while bit_ready is low; in_ready depends only on registered state and rst_n.
module mux_sel_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  output logic busy,
  mux_sel_sequencer_if.master seq
);
  state_t            state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [NUM_IN-1:0] word_q;
  logic              valid_q;
  logic              first_q;
  sel_t              sel_q;
  logic              at_term;
  logic              accept;
  logic              xfer;

  assign accept = (state == IDLE) && seq.in_valid;
  assign xfer   = valid_q && seq.bit_ready;

  // The counter stops at the terminal, so the last transfer never advances sel.
  mux_sel_counter #(.DOWN(MSB_FIRST)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .load     (accept && !flush),
    .en       (xfer && !at_term && !flush),
    .load_val (MSB_FIRST ? seq.in_nbits : sel_t'(0)),
    .term_val (MSB_FIRST ? sel_t'(0) : seq.in_nbits),
    .q        (sel_q),
    .at_term  (at_term)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      word_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      gap_cnt <= '0;
    end else if (flush) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seq.in_valid) begin
            word_q  <= seq.in_data;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            first_q <= 1'b0;
            if (at_term) begin
              valid_q <= 1'b0;
              state   <= IDLE;
            end else if (GAP_CYCLES != 0) begin
              valid_q <= 1'b0;
              gap_cnt <= GAP_W'(GAP_CYCLES - 1);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            valid_q <= 1'b1;
            state   <= SHIFT;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign seq.in_ready  = (state == IDLE) && rst_n;
  assign seq.d_out     = word_q;
  assign seq.sel       = sel_q;
  assign seq.bit_valid = valid_q;
  assign seq.first     = first_q;
  assign seq.last      = valid_q && at_term;
endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Two sequencers (LSB-first no gap, MSB-first gap 2) on shared stimulus, each tracked by its own reference.
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;

  localparam int GAP_A = 0;
  localparam int GAP_B = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, flush, in_valid, bit_ready, cap_clr;
  logic [7:0] in_data;
  sel_t       in_nbits;
  logic       busy_a, busy_b;

  mux_sel_sequencer_if ia();
  mux_sel_sequencer_if ib();

  assign ia.in_valid  = in_valid;
  assign ia.in_data   = in_data;
  assign ia.in_nbits  = in_nbits;
  assign ia.bit_ready = bit_ready;
  assign ib.in_valid  = in_valid;
  assign ib.in_data   = in_data;
  assign ib.in_nbits  = in_nbits;
  assign ib.bit_ready = bit_ready;

  mux_sel_sequencer #(.GAP_CYCLES(GAP_A), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy_a), .seq(ia.master)
  );
  mux_sel_sequencer #(.GAP_CYCLES(GAP_B), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .busy(busy_b), .seq(ib.master)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: a word is a list of bit indices j=0..n, visited at position j (up) or n-j (down).
  string      nm[2]    = '{"a", "b"};
  int         gap_p[2] = '{GAP_A, GAP_B};
  bit         msb_p[2] = '{1'b0, 1'b1};
  bit         m_act[2];
  logic [7:0] m_word[2];
  int         m_n[2], m_j[2], m_gap[2], m_idle_sel[2];
  logic       p_v[2];
  logic [7:0] p_d[2];
  sel_t       p_s[2];
  logic [15:0] cap[2];

  function automatic int pos_of(input int id, input int j);
    return msb_p[id] ? m_n[id] - j : j;
  endfunction

  task automatic step(input int id, input logic [7:0] d, input sel_t s, input logic v,
                      input logic f, input logic l, input logic bsy, input logic rdy);
    string t = nm[id];
    int    ps;
    logic  ev;
    if (cap_clr) cap[id] = '0;
    if (p_v[id] && bit_ready && rst_n && !flush)
      cap[id] = {cap[id][14:0], p_d[id][p_s[id]]};
    if (!rst_n) begin
      m_act[id] = 1'b0; m_word[id] = '0; m_idle_sel[id] = 0; m_gap[id] = 0;
    end else if (flush) begin
      m_act[id] = 1'b0; m_idle_sel[id] = 0; m_gap[id] = 0;
    end else if (!m_act[id]) begin
      if (in_valid) begin
        m_act[id] = 1'b1; m_word[id] = in_data; m_n[id] = int'(in_nbits);
        m_j[id] = 0; m_gap[id] = 0;
      end
    end else if (m_gap[id] > 0) begin
      m_gap[id]--;
    end else if (bit_ready) begin
      if (m_j[id] == m_n[id]) begin
        m_act[id] = 1'b0;
        m_idle_sel[id] = pos_of(id, m_j[id]);
      end else begin
        m_j[id]++;
        m_gap[id] = gap_p[id];
      end
    end
    ev = m_act[id] && (m_gap[id] == 0);
    ps = m_act[id] ? pos_of(id, m_j[id]) : m_idle_sel[id];
    chk({t, ".busy"}, bsy, m_act[id]);
    chk({t, ".in_ready"}, rdy, !m_act[id] && rst_n);
    chk({t, ".bit_valid"}, v, ev);
    chk({t, ".sel"}, s, sel_t'(ps));
    chk({t, ".d_out"}, d, m_word[id]);
    chk({t, ".first"}, f, ev && (m_j[id] == 0));
    chk({t, ".last"}, l, ev && (m_j[id] == m_n[id]));
    if (ev) chk({t, ".bit"}, d[s], m_word[id][ps]);
    p_v[id] = v; p_d[id] = d; p_s[id] = s;
  endtask

  // Inputs change 1 time unit after the falling edge; outputs are checked on it.
  task automatic tick();
    @(negedge clk);
    step(0, ia.d_out, ia.sel, ia.bit_valid, ia.first, ia.last, busy_a, ia.in_ready);
    step(1, ib.d_out, ib.sel, ib.bit_valid, ib.first, ib.last, busy_b, ib.in_ready);
    #1;
  endtask

  task automatic send(input logic [7:0] data, input sel_t nb);
    cap_clr  = 1'b1;
    in_valid = 1'b1;
    in_data  = data;
    in_nbits = nb;
    tick();
    cap_clr  = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!busy_a && !busy_b) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  task automatic wait_sel(input int id, input sel_t s, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (id == 0 ? (ia.bit_valid && ia.sel == s) : (ib.bit_valid && ib.sel == s)) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, ok, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_nbits = '0;
    bit_ready = 1'b1; cap_clr = 1'b0;
    tick();
    tick();
    chk("rst.a.d_out", ia.d_out, 8'h00);
    chk("rst.b.bit_valid", ib.bit_valid, 1'b0);
    chk("rst.a.in_ready", ia.in_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("rel.a.in_ready", ia.in_ready, 1'b1);
    chk("rel.b.busy", busy_b, 1'b0);

    send(8'hA5, 3'd7);
    wait_idle("a5.done");
    chk("a5.a.stream", cap[0], 16'h00A5);
    chk("a5.b.stream", cap[1], 16'h00A5);

    send(8'h0C, 3'd3);
    wait_idle("0c.done");
    chk("0c.a.stream", cap[0], 16'h0003);
    chk("0c.b.stream", cap[1], 16'h000C);

    send(8'h5A, 3'd7);
    wait_sel(1, 3'd2, "bp.wait");
    bit_ready = 1'b0;
    repeat (3) tick();
    bit_ready = 1'b1;
    wait_idle("bp.done");
    chk("bp.b.stream", cap[1], 16'h005A);

    send(8'h01, 3'd0);
    wait_idle("one.done");
    chk("one.a.stream", cap[0], 16'h0001);
    chk("one.b.stream", cap[1], 16'h0001);

    send(8'h3C, 3'd7);
    wait_sel(0, 3'd4, "fl.wait");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl.a.bit_valid", ia.bit_valid, 1'b0);
    chk("fl.a.sel", ia.sel, 3'd0);
    chk("fl.a.d_out", ia.d_out, 8'h3C);
    chk("fl.a.busy", busy_a, 1'b0);
    tick();

    send(8'hC3, 3'd7);
    wait_sel(0, 3'd4, "rs.wait");
    rst_n = 1'b0;
    tick();
    chk("rs.a.d_out", ia.d_out, 8'h00);
    chk("rs.a.sel", ia.sel, 3'd0);
    chk("rs.b.bit_valid", ib.bit_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    repeat (3000) begin
      rst_n     = ($urandom_range(0, 99) > 1);
      flush     = ($urandom_range(0, 99) < 3);
      in_valid  = $urandom_range(0, 1) != 0;
      in_data   = 8'($urandom);
      in_nbits  = sel_t'($urandom_range(0, 7));
      bit_ready = $urandom_range(0, 3) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
